mem_arb2: RTL

//  Two-requester arbiter/sequencer in front of the single-port DFF memory (mem8x16).

---
 rtl/mem_arb2.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arb2.sv
// mem_arb2 -- two-requester round-robin arbiter in front of a single-port memory
//
// Grants at most one memory access per cycle. Contention is resolved by a
// round-robin pointer that flips to the losing requester. Reads return with a
// fixed latency of one cycle and are steered back to the requester that issued
// them. Writes complete at acceptance.
//
// Optional feature (macro MEM_ARB_CLEAR_EN): after reset the arbiter sweeps
// addresses 0..CLR_DEPTH-1 to zero, one word per cycle, with busy=1 and both
// readies held low. Without the macro, serving starts right after reset and
// busy is tied low.
//
// Ports
//   clk                 clock
//   rst                 synchronous, active-high reset
//   rN_valid/rN_ready   request handshake for requester N (accept = valid & ready)
//   rN_we               1 = write, 0 = read
//   rN_addr/rN_wdata    request address / write data
//   rN_rvalid/rN_rdata  one-cycle read-return pulse and its data (data holds after)
//   busy                high during the post-reset clear sweep
//   mem_cs/mem_we       memory chip select / write enable
//   mem_addr/mem_din    memory address / write data (hold when idle)
//   mem_dout            memory read data, valid one cycle after a read
module mem_arb2 #(
   parameter int AW        = 12,
   parameter int DW        = 16,
   parameter int CLR_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          r0_valid,
   output logic          r0_ready,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_rvalid,
   output logic [DW-1:0] r0_rdata,
   input  logic          r1_valid,
   output logic          r1_ready,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,
   output logic          busy,
   output logic          mem_cs,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   logic          serving;      // arbitration enabled this cycle (state only, rst gated separately)
   logic          clr_active;   // clear-sweep write happening this cycle
   logic [AW-1:0] clr_addr;

   logic          rr_ptr_reg;   // requester that wins the next contention
   logic [1:0]    rd_tag_reg;   // one-hot: which requester has a read returning now
   logic [AW-1:0] addr_hold_reg;
   logic [DW-1:0] din_hold_reg;
   logic [DW-1:0] rdata_hold_reg [2];

   logic [1:0]    req;
   logic [1:0]    grant;
   logic [1:0]    req_we;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_din;
   logic [1:0]    rvalid;
   logic [DW-1:0] rdata [2];

`ifdef MEM_ARB_CLEAR_EN
   localparam int CW = (CLR_DEPTH > 1) ? $clog2(CLR_DEPTH) : 1;
   localparam logic [CW-1:0] CLR_LAST = CW'(CLR_DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

   state_t        state_reg;
   logic [CW-1:0] clr_cnt_reg;

   // Sweep one address per cycle; leaving on the last address makes the
   // sweep exactly CLR_DEPTH cycles long.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_CLEAR;
         clr_cnt_reg <= '0;
      end else if (state_reg == ST_CLEAR) begin
         if (clr_cnt_reg == CLR_LAST) begin
            state_reg   <= ST_SERVE;
            clr_cnt_reg <= '0;
         end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
         end
      end
   end

   assign serving    = (state_reg == ST_SERVE);
   assign clr_active = !rst && (state_reg == ST_CLEAR);
   assign busy       = (state_reg == ST_CLEAR);
   assign clr_addr   = AW'(clr_cnt_reg);
`else
   assign serving    = 1'b1;
   assign clr_active = 1'b0;
   assign busy       = 1'b0;
   assign clr_addr   = '0;
`endif

   assign req    = {r1_valid, r0_valid};
   assign req_we = {r1_we, r0_we};

   // Requests seen during reset are refused so nothing is accepted (and no
   // read tag is set) in the reset cycle.
   always_comb begin
      grant = 2'b00;
      if (!rst && serving) begin
         grant[0] = req[0] & (~req[1] | ~rr_ptr_reg);
         grant[1] = req[1] & ~grant[0];
      end
   end

   assign r0_ready = grant[0];
   assign r1_ready = grant[1];

   assign sel_we   = grant[1] ? r1_we    : r0_we;
   assign sel_addr = grant[1] ? r1_addr  : r0_addr;
   assign sel_din  = grant[1] ? r1_wdata : r0_wdata;

   always_comb begin
      mem_cs   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = addr_hold_reg;
      mem_din  = din_hold_reg;
      if (clr_active) begin
         mem_cs   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = clr_addr;
         mem_din  = '0;
      end else if (|grant) begin
         mem_cs   = 1'b1;
         mem_we   = sel_we;
         mem_addr = sel_addr;
         mem_din  = sel_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg    <= 1'b0;
         rd_tag_reg    <= 2'b00;
         addr_hold_reg <= '0;
         din_hold_reg  <= '0;
      end else begin
         // Winner is rr_ptr_reg on contention, so toggling hands priority to the loser.
         if (serving && (&req))
            rr_ptr_reg <= ~rr_ptr_reg;
         rd_tag_reg <= grant & ~req_we;
         if (mem_cs) begin
            addr_hold_reg <= mem_addr;
            din_hold_reg  <= mem_din;
         end
      end
   end

   // Per-requester read return: pulse straight from the tag, data passes
   // mem_dout through during the pulse and holds it afterwards.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ret
         assign rvalid[gi] = rd_tag_reg[gi] & ~rst;
         assign rdata[gi]  = rvalid[gi] ? mem_dout : rdata_hold_reg[gi];

         always_ff @(posedge clk) begin
            if (rst)
               rdata_hold_reg[gi] <= '0;
            else if (rd_tag_reg[gi])
               rdata_hold_reg[gi] <= mem_dout;
         end
      end
   endgenerate

   assign r0_rvalid = rvalid[0];
   assign r1_rvalid = rvalid[1];
   assign r0_rdata  = rdata[0];
   assign r1_rdata  = rdata[1];

endmodule
